imem_loader: RTL

//   Write side of the byte-addressed instruction memory: receives a framed byte stream, writes it into iMem.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_xsum.sv | 24 ++
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM state encoding (also exported on the debug port)
//   HDR_BYTES      : bytes in a frame header (ADDR_HI, ADDR_LO, LEN_HI, LEN_LO)
//   DEF_MEM_BYTES  : default instruction memory size in bytes
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    H_AH,
    H_AL,
    H_LH,
    H_LL,
    PAYLOAD,
    CHECK
  } loader_state_t;

  localparam int HDR_BYTES     = 4;
  localparam int DEF_MEM_BYTES = 128;

endpackage

// File: rtl/imem_loader_xsum.sv
// imem_loader_xsum: running XOR of every byte accepted in a frame.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the accumulator (start of a new frame)
//   en         : fold din into the accumulator this cycle
//   din        : byte to fold in
//   acc        : XOR of all bytes folded in since the last clear
module imem_loader_xsum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= 8'h00;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes its payload into the
// byte-addressed instruction memory, holding the CPU for the duration.
// Frame: ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, LEN payload bytes [, XSUM].
// Optional feature macro: IMEM_LOADER_XSUM_EN (adds the trailing XOR checksum
// byte and the CHECK state; without it no accumulator is built).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start                 : begin a load (only looked at in IDLE)
//   rx_data/rx_valid      : incoming stream byte and its valid
//   rx_ready              : loader will take a byte this cycle
//   mem_we/addr/wdata     : registered byte write port to iMem
//   busy, done, error     : load in progress, completion pulse, sticky fault
//   cpu_hold              : stall the CPU while high
//   dbg_state             : current FSM state
// Handshake: a byte moves on any rising edge where rx_valid and rx_ready are
// both high; the producer holds rx_data stable while rx_valid is high and not
// yet accepted. rx_ready is registered and depends only on loader state.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output loader_state_t     dbg_state
);

  loader_state_t     state;
  logic              xfer;
  logic [7:0]        addr_hi;
  logic [7:0]        len_hi;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] len_w;
  logic [ADDR_W:0]   end_addr;
  logic              too_long;

  assign xfer      = rx_valid & rx_ready;
  assign dbg_state = state;

  // Length completes on the LEN_LO byte itself; the range check uses one
  // extra bit so ADDR+LEN cannot wrap back into range.
  always_comb begin
    len_w    = ADDR_W'({len_hi, rx_data});
    end_addr = {1'b0, cur} + {1'b0, len_w};
    too_long = end_addr > (ADDR_W + 1)'(MEM_BYTES);
  end

`ifdef IMEM_LOADER_XSUM_EN
  logic [7:0] xsum_acc;
  logic       xsum_pass;

  imem_loader_xsum u_xsum (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE && start),
    .en    (xfer),
    .din   (rx_data),
    .acc   (xsum_acc)
  );

  // The XSUM byte itself is folded in here so the verdict is available on
  // the same edge it is accepted.
  assign xsum_pass = (xsum_acc ^ rx_data) == 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b0;
      addr_hi   <= 8'h00;
      len_hi    <= 8'h00;
      cur       <= '0;
      remaining <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= H_AH;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            error    <= 1'b0;
          end
        end
        H_AH: begin
          if (xfer) begin
            addr_hi <= rx_data;
            state   <= H_AL;
          end
        end
        H_AL: begin
          if (xfer) begin
            cur   <= ADDR_W'({addr_hi, rx_data});
            state <= H_LH;
          end
        end
        H_LH: begin
          if (xfer) begin
            len_hi <= rx_data;
            state  <= H_LL;
          end
        end
        H_LL: begin
          if (xfer) begin
            remaining <= len_w;
            if (too_long) begin
              state    <= IDLE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              error    <= 1'b1;
            end else if (len_w == '0) begin
`ifdef IMEM_LOADER_XSUM_EN
              state <= CHECK;
`else
              state    <= IDLE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= cur;
            mem_wdata <= rx_data;
            cur       <= cur + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
`ifdef IMEM_LOADER_XSUM_EN
              state <= CHECK;
`else
              // Final write and done land on the same cycle.
              state    <= IDLE;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
`endif
            end
          end
        end
        CHECK: begin
`ifdef IMEM_LOADER_XSUM_EN
          if (xfer) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            if (xsum_pass) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
`else
          state    <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
`endif
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule
